t03_layer_fetch_arbiter: RTL and testbench
==========================================

T03_LAYER_FETCH_ARBITER -- requirements
Module: t03_layer_fetch_arbiter

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  ADDR_W, 12, sprite/glyph memory address width
  DATA_W, 8, pixel colour width (RRRGGGBB)
REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  system clock
  nrst  in  1  asynchronous active-low reset
  fetch_en  in  1  grant window; new grants only while high
  frame_start  in  1  one-cycle pulse at top of frame
  req_valid  in  3  request per requester: [0]=player 1, [1]=player 2, [2]=text
  req_addr  in  3*ADDR_W  address per requester; slice i = bits [i*ADDR_W +: ADDR_W]
  req_ready  out  3  one-hot grant acknowledge
  rsp_valid  out  3  one-hot read-data strobe
  rsp_data  out  DATA_W  read data for the strobed requester
  mem_ren  out  1  shared memory read enable
  mem_addr  out  ADDR_W  shared memory address
  mem_rdata  in  DATA_W  memory data, valid the cycle after mem_ren
  busy  out  1  high in any state other than IDLE
  fetch_cnt  out  16  grants since the last frame_start, saturating
REQ-003 Clock SHALL be clk; reset SHALL be nrst, asynchronous assert, active-low; one clock domain only.

Function
REQ-004 FSM SHALL have states IDLE, ISSUE, READ; one transaction in flight at most.
REQ-005 IDLE: if fetch_en=1 and any req_valid=1, the block SHALL pick winner w, register mem_addr<=req_addr[w], mem_ren<=1, req_ready[w]<=1, and go to ISSUE; otherwise it SHALL stay in IDLE with mem_ren=0 and req_ready=0.
REQ-006 ISSUE SHALL last exactly one cycle with mem_ren=1 and req_ready[w]=1, then go to READ with mem_ren<=0 and req_ready<=0.
REQ-007 READ SHALL register rsp_data<=mem_rdata and rsp_valid[w]<=1, then go to IDLE; rsp_valid SHALL be high for exactly the following cycle.
REQ-008 Latency: req_valid sampled in IDLE at cycle T -> req_ready/mem_ren high in T+1 -> rsp_valid high in T+3; peak throughput SHALL be one grant per 3 cycles.
REQ-009 A requester holds req_valid and req_addr stable until req_ready is seen; the block SHALL sample req_addr only in IDLE.
REQ-010 Arbitration SHALL be round-robin: after a grant to w, the search order SHALL start at (w+1) mod 3; requesters with req_valid=0 are skipped.
REQ-011 The round-robin pointer SHALL reset to 0, giving order 0,1,2 (player 1 first).
REQ-012 frame_start SHALL set the pointer to 0 and fetch_cnt to 0 at the next edge; if it coincides with a grant, the clear SHALL win and that grant SHALL NOT be counted.
REQ-013 fetch_cnt SHALL increment on each IDLE->ISSUE transition and saturate at 16'hFFFF.
REQ-014 fetch_en=0 in ISSUE or READ SHALL NOT abort the transaction; it SHALL only block the next grant.
REQ-015 busy SHALL be 1 in ISSUE and READ and 0 in IDLE.

Reset
REQ-016 On nrst=0 the block SHALL force: state=IDLE, pointer=0, req_ready=0, rsp_valid=0, rsp_data=0, mem_ren=0, mem_addr=0, fetch_cnt=0, busy=0.
REQ-017 On reset during ISSUE or READ the transaction SHALL be dropped: no rsp_valid after release.
REQ-018 After release, the first grant SHALL be possible in the first cycle with nrst=1.

Structure
REQ-019 Package t03_fetch_pkg SHALL hold the state enum (IDLE, ISSUE, READ), the requester IDs REQ_P1=0, REQ_P2=1, REQ_TEXT=2, and the requester count 3.
REQ-020 The combinational round-robin winner picker SHALL be sub-module t03_rr_arbiter3 (inputs: req[2:0], ptr[1:0]; outputs: gnt one-hot, gnt_id, any).

Verification
REQ-021 Scenario: only req_valid[1] high, addr 12'h0A5, mem returns 8'h57 -> req_ready=3'b010 at T+1, mem_addr=12'h0A5, rsp_valid=3'b010, and rsp_data=8'h57 at T+3.
REQ-022 Scenario: all three req_valid held high after reset -> grants in order 0,1,2,0 at T+1, T+4, T+7, T+10.
REQ-023 Scenario: req_valid[0] high with fetch_en=0 -> no mem_ren; fetch_en raised at T -> req_ready[0] at T+1; fetch_en dropped during ISSUE -> rsp_valid[0] still at T+3.
REQ-024 Scenario: nrst pulsed low during READ -> all outputs 0, no rsp_valid afterwards, state IDLE.
REQ-025 Scenario: 5 grants then frame_start -> fetch_cnt=5 then 0; next contending grant goes to requester 0; forced count 16'hFFFF plus one grant stays 16'hFFFF.

Source files
------------

// File: rtl/t03_fetch_pkg.sv
// Layer fetch arbiter shared types.
// FSM states, requester IDs and pointer helper.
package t03_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    READ  = 2'd2
  } state_t;

  localparam int N_REQ = 3;

  localparam logic [1:0] REQ_P1   = 2'd0;
  localparam logic [1:0] REQ_P2   = 2'd1;
  localparam logic [1:0] REQ_TEXT = 2'd2;

  function automatic logic [1:0] next_ptr(input logic [1:0] id);
    return (id >= REQ_TEXT) ? REQ_P1 : id + 2'd1;
  endfunction

endpackage

// File: rtl/t03_rr_arbiter3.sv
// Three-way round-robin winner picker.
// Search starts at ptr and wraps; idle requesters skipped.
module t03_rr_arbiter3
  import t03_fetch_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ptr,
  output logic [2:0] gnt,
  output logic [1:0] gnt_id,
  output logic       any
);

  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;

  // walk the three candidates in pointer order
  always_comb begin
    c0     = (ptr > REQ_TEXT) ? REQ_P1 : ptr;
    c1     = next_ptr(c0);
    c2     = next_ptr(c1);
    gnt_id = REQ_P1;
    if (req[c0])      gnt_id = c0;
    else if (req[c1]) gnt_id = c1;
    else if (req[c2]) gnt_id = c2;
    any = |req;
    gnt = any ? (3'b001 << gnt_id) : 3'b000;
  end

endmodule

// File: rtl/t03_layer_fetch_arbiter.sv
// Shared sprite/glyph memory fetch arbiter.
// Three requesters, one read in flight, 3-cycle grant cadence.
module t03_layer_fetch_arbiter
  import t03_fetch_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  fetch_en,
  input  logic                  frame_start,
  input  logic [2:0]            req_valid,
  input  logic [3*ADDR_W-1:0]   req_addr,
  output logic [2:0]            req_ready,
  output logic [2:0]            rsp_valid,
  output logic [DATA_W-1:0]     rsp_data,
  output logic                  mem_ren,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic                  busy,
  output logic [15:0]           fetch_cnt
);

  state_t            state_q;
  logic [1:0]        ptr_q;
  logic [1:0]        w_q;
  logic [15:0]       cnt_q;
  logic [2:0]        gnt;
  logic [1:0]        gnt_id;
  logic              any;
  logic              grant;
  logic [ADDR_W-1:0] sel_addr;

  t03_rr_arbiter3 u_arb (
    .req    (req_valid),
    .ptr    (ptr_q),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .any    (any)
  );

  assign grant     = (state_q == IDLE) && fetch_en && any;
  assign sel_addr  = req_addr[gnt_id*ADDR_W +: ADDR_W];
  assign busy      = (state_q != IDLE);
  assign fetch_cnt = cnt_q;

  // transaction sequencer: grant, issue read, return data
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= IDLE;
      w_q       <= REQ_P1;
      req_ready <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
      mem_ren   <= 1'b0;
      mem_addr  <= '0;
    end else begin
      rsp_valid <= '0;
      case (state_q)
        IDLE: begin
          if (grant) begin
            state_q   <= ISSUE;
            w_q       <= gnt_id;
            mem_addr  <= sel_addr;
            mem_ren   <= 1'b1;
            req_ready <= gnt;
          end
        end
        ISSUE: begin
          state_q   <= READ;
          mem_ren   <= 1'b0;
          req_ready <= '0;
        end
        READ: begin
          state_q   <= IDLE;
          rsp_data  <= mem_rdata;
          rsp_valid <= 3'b001 << w_q;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // fairness pointer and per-frame grant count; frame clear wins
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ptr_q <= REQ_P1;
      cnt_q <= '0;
    end else if (frame_start) begin
      ptr_q <= REQ_P1;
      cnt_q <= '0;
    end else if (grant) begin
      ptr_q <= next_ptr(gnt_id);
      if (cnt_q != 16'hFFFF) cnt_q <= cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_t03_layer_fetch_arbiter.sv
// Bench for t03_layer_fetch_arbiter.
// Transaction-level model, directed scenarios, random traffic.
module tb_t03_layer_fetch_arbiter;

  localparam int AW = 12;
  localparam int DW = 8;

  logic            clk = 1'b0;
  logic            nrst = 1'b0;
  logic            fetch_en = 1'b0;
  logic            frame_start = 1'b0;
  logic [2:0]      req_valid = '0;
  logic [3*AW-1:0] req_addr = '0;
  logic [2:0]      req_ready;
  logic [2:0]      rsp_valid;
  logic [DW-1:0]   rsp_data;
  logic            mem_ren;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_rdata = '0;
  logic            busy;
  logic [15:0]     fetch_cnt;

  logic [DW-1:0]   mem [0:4095];

  int checks = 0;
  int errors = 0;

  // model: grant taken at edge g_edge, data returned at g_edge+2
  int            edge_n = 0;
  int            g_edge = -100;
  int            g_id = 0;
  int            ptr = 0;
  int            cnt = 0;
  logic [AW-1:0] g_addr = '0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_data = '0;

  logic [2:0] rr_exp [12] = '{3'b001, 3'b000, 3'b000, 3'b010,
                              3'b000, 3'b000, 3'b100, 3'b000,
                              3'b000, 3'b001, 3'b000, 3'b000};

  always #5 clk = ~clk;

  t03_layer_fetch_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .nrst        (nrst),
    .fetch_en    (fetch_en),
    .frame_start (frame_start),
    .req_valid   (req_valid),
    .req_addr    (req_addr),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_data    (rsp_data),
    .mem_ren     (mem_ren),
    .mem_addr    (mem_addr),
    .mem_rdata   (mem_rdata),
    .busy        (busy),
    .fetch_cnt   (fetch_cnt)
  );

  // synchronous memory: data the cycle after mem_ren
  always @(posedge clk)
    if (mem_ren) mem_rdata <= mem[mem_addr];

  task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic model_edge();
    bit found;
    int i;
    if (!nrst) begin
      g_edge = -100; ptr = 0; cnt = 0;
      m_addr = '0; m_data = '0;
      return;
    end
    if (edge_n == g_edge + 2) m_data = mem[g_addr];
    if (edge_n >= g_edge + 3 && fetch_en && req_valid != 3'b000) begin
      found = 0;
      for (int k = 0; k < 3; k++) begin
        i = (ptr + k) % 3;
        if (!found && req_valid[i]) begin
          g_id = i; found = 1;
        end
      end
      g_edge = edge_n;
      g_addr = req_addr[g_id*AW +: AW];
      m_addr = g_addr;
      ptr = (g_id + 1) % 3;
      if (!frame_start && cnt < 65535) cnt++;
    end
    if (frame_start) begin
      ptr = 0; cnt = 0;
    end
  endtask

  function automatic logic [2:0] exp_ready();
    return (edge_n == g_edge) ? 3'(1 << g_id) : 3'b000;
  endfunction

  task automatic compare();
    logic [2:0] er;
    logic [2:0] ev;
    er = exp_ready();
    ev = (edge_n == g_edge + 2) ? 3'(1 << g_id) : 3'b000;
    chk("req_ready", req_ready, er);
    chk("mem_ren", mem_ren, er != 3'b000);
    chk("mem_addr", mem_addr, m_addr);
    chk("rsp_valid", rsp_valid, ev);
    chk("rsp_data", rsp_data, m_data);
    chk("busy", busy, (edge_n == g_edge) || (edge_n == g_edge + 1));
    chk("fetch_cnt", fetch_cnt, cnt);
  endtask

  task automatic step();
    @(posedge clk);
    edge_n++;
    model_edge();
    @(negedge clk);
    compare();
  endtask

  task automatic pulse_reset();
    nrst = 1'b0;
    step();
    nrst = 1'b1;
  endtask

  initial begin
    for (int a = 0; a < 4096; a++) mem[a] = 8'($urandom);
    mem[12'h0A5] = 8'h57;

    // reset state
    step();
    step();
    chk("rst_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cnt", fetch_cnt, 0);

    // single requester, first cycle out of reset
    nrst = 1'b1;
    fetch_en = 1'b1;
    req_valid = 3'b010;
    req_addr[1*AW +: AW] = 12'h0A5;
    step();
    chk("s1_ready", req_ready, 3'b010);
    chk("s1_addr", mem_addr, 12'h0A5);
    chk("s1_cnt", fetch_cnt, 1);
    req_valid = 3'b000;
    step();
    step();
    chk("s1_rsp_valid", rsp_valid, 3'b010);
    chk("s1_rsp_data", rsp_data, 8'h57);
    pulse_reset();

    // all contending: order 0,1,2,0 every 3 cycles
    for (int i = 0; i < 3; i++) req_addr[i*AW +: AW] = 12'($urandom);
    req_valid = 3'b111;
    for (int k = 0; k < 12; k++) begin
      step();
      chk($sformatf("rr_order_%0d", k), req_ready, rr_exp[k]);
    end
    req_valid = 3'b000;
    pulse_reset();

    // fetch_en gating and non-abort
    fetch_en = 1'b0;
    req_valid = 3'b001;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("gate_ren", mem_ren, 0);
    end
    fetch_en = 1'b1;
    step();
    chk("gate_ready", req_ready, 3'b001);
    fetch_en = 1'b0;
    req_valid = 3'b000;
    step();
    step();
    chk("gate_rsp", rsp_valid, 3'b001);

    // reset during READ drops the transaction
    fetch_en = 1'b1;
    req_valid = 3'b001;
    step();
    req_valid = 3'b000;
    step();
    chk("rd_busy", busy, 1);
    nrst = 1'b0;
    #1;
    chk("ar_ready", req_ready, 0);
    chk("ar_rsp", rsp_valid, 0);
    chk("ar_ren", mem_ren, 0);
    chk("ar_addr", mem_addr, 0);
    chk("ar_data", rsp_data, 0);
    chk("ar_busy", busy, 0);
    step();
    nrst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("ar_no_rsp", rsp_valid, 0);
    end

    // counting, frame clear, saturation
    req_valid = 3'b111;
    for (int k = 0; k < 15; k++) step();
    chk("cnt_five", fetch_cnt, 5);
    req_valid = 3'b000;
    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    chk("cnt_clear", fetch_cnt, 0);
    req_valid = 3'b111;
    step();
    chk("ptr_clear", req_ready, 3'b001);
    req_valid = 3'b000;
    step();
    step();
    force dut.cnt_q = 16'hFFFF;
    cnt = 65535;
    step();
    release dut.cnt_q;
    chk("cnt_forced", fetch_cnt, 16'hFFFF);
    req_valid = 3'b001;
    step();
    chk("sat_ready", req_ready, 3'b001);
    chk("sat_cnt", fetch_cnt, 16'hFFFF);
    req_valid = 3'b000;
    step();
    step();
    pulse_reset();

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      logic [2:0] er;
      er = exp_ready();
      for (int i = 0; i < 3; i++) begin
        if (req_valid[i] && er[i]) begin
          req_valid[i] = 1'($urandom_range(0, 1));
          req_addr[i*AW +: AW] = 12'($urandom);
        end else if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
          req_valid[i] = 1'b1;
          req_addr[i*AW +: AW] = 12'($urandom);
        end
      end
      fetch_en = ($urandom_range(0, 9) != 0);
      frame_start = ($urandom_range(0, 29) == 0);
      if (!nrst) nrst = 1'b1;
      else nrst = ($urandom_range(0, 199) != 0);
      step();
    end

    nrst = 1'b1;
    req_valid = 3'b000;
    frame_start = 1'b0;
    for (int k = 0; k < 4; k++) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
